// File: rtl/up3_pkg.sv
// Shared types and default widths for the RAM arbiter.
package up3_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_WAIT
   } arb_state_t;

   localparam int ARB_AW = 8;
   localparam int ARB_DW = 8;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request at or after ptr_i wins.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   logic [PW-1:0] cand;

   // NOTE: combinational logic uses blocking assignments with a default for every output first, so no latch is inferred.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      // Scan from lowest priority to highest so the last hit is the winner.
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = PW'((int'(ptr_i) + k) % NREQ);
         if (req_i[cand]) begin
            idx_o = cand;
            any_o = 1'b1;
         end
      end
      onehot_o = any_o ? (NREQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ requesters.
// One transaction in flight; grant and read-valid are one-cycle pulses.
module ram_arbiter
   import up3_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int AW     = ARB_AW,
   parameter int DW     = ARB_DW,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      ram_address,
   output logic [DW-1:0]      ram_data,
   output logic               ram_wren,
   input  logic [DW-1:0]      ram_q
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   ptr_q;
   logic [NREQ-1:0] win_oh_q;
   logic            we_q;
   logic [1:0]      wait_cnt_q;
   logic [AW-1:0]   ram_address_q;
   logic [DW-1:0]   ram_data_q;
   logic [DW-1:0]   rdata_q;
   logic [NREQ-1:0] rvalid_q;

   logic [NREQ-1:0] pick_oh;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            arb_take;
   logic            rd_done;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   assign arb_take = (state_q == ARB_IDLE) && pick_any;
   assign rd_done  = (state_q == ARB_WAIT) && (wait_cnt_q == '0);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ARB_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (pick_any) state_d = ARB_ACCESS;
         ARB_ACCESS: state_d = we_q ? ARB_IDLE : ARB_WAIT;
         ARB_WAIT:   if (wait_cnt_q == '0) state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   // The latched address/data double as the RAM-facing registers, so they hold between accesses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q         <= '0;
         win_oh_q      <= '0;
         we_q          <= 1'b0;
         wait_cnt_q    <= '0;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         rdata_q       <= '0;
         rvalid_q      <= '0;
      end else begin
         if (arb_take) begin
            ptr_q         <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            win_oh_q      <= pick_oh;
            we_q          <= we[pick_idx];
            ram_address_q <= addr[int'(pick_idx) * AW +: AW];
            ram_data_q    <= wdata[int'(pick_idx) * DW +: DW];
         end
         if (state_q == ARB_ACCESS)
            wait_cnt_q <= 2'(RD_LAT - 1);
         else if ((state_q == ARB_WAIT) && !rd_done)
            wait_cnt_q <= wait_cnt_q - 1'b1;
         if (rd_done) rdata_q <= ram_q;
         rvalid_q <= rd_done ? win_oh_q : '0;
      end
   end

   always_comb begin
      gnt         = '0;
      ram_wren    = 1'b0;
      rvalid      = rvalid_q;
      rdata       = rdata_q;
      ram_address = ram_address_q;
      ram_data    = ram_data_q;
      if (state_q == ARB_ACCESS) begin
         gnt      = win_oh_q;
         ram_wren = we_q;
      end
   end

endmodule
